// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder: Gray positions, move classification
// and the phase count that makes up one full detent.
package enc_pkg;

    typedef enum logic [1:0] {
        GRAY_DETENT = 2'b00,
        GRAY_Q1     = 2'b10,
        GRAY_Q2     = 2'b11,
        GRAY_Q3     = 2'b01
    } gray_t;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_CW,
        MOVE_CCW,
        MOVE_ILLEGAL
    } move_t;

    localparam int PHASE_FULL = 4;

    // Position of a Gray code along the clockwise cycle 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        case (g)
            GRAY_DETENT: gray_pos = 2'd0;
            GRAY_Q1:     gray_pos = 2'd1;
            GRAY_Q2:     gray_pos = 2'd2;
            default:     gray_pos = 2'd3;
        endcase
    endfunction

    function automatic move_t cw_move(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    cw_move = MOVE_NONE;
            2'd1:    cw_move = MOVE_CW;
            2'd3:    cw_move = MOVE_CCW;
            default: cw_move = MOVE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_phase.sv
// Tracks the previous {a,b} sample and the signed phase within a detent; emits
// combinational step_cw / step_ccw / illegal pulses for the current cycle.
module quad_phase
    import enc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic step_cw,
    output logic step_ccw,
    output logic illegal
);

    localparam logic signed [3:0] PHASE_POS = 4'(PHASE_FULL);
    localparam logic signed [3:0] PHASE_NEG = -PHASE_POS;

    logic [1:0]        prev_ab;
    logic              primed;
    logic signed [3:0] phase;
    logic signed [3:0] phase_next;
    logic [1:0]        cur_ab;
    move_t             move;

    assign cur_ab = {a, b};

    always_comb begin
        move       = primed ? cw_move(prev_ab, cur_ab) : MOVE_NONE;
        phase_next = phase;
        step_cw    = 1'b0;
        step_ccw   = 1'b0;
        illegal    = 1'b0;
        case (move)
            MOVE_CW:      phase_next = phase + 4'sd1;
            MOVE_CCW:     phase_next = phase - 4'sd1;
            MOVE_ILLEGAL: begin
                illegal    = 1'b1;
                phase_next = 4'sd0;
            end
            default: ;
        endcase
        // Arriving at the detent settles the detent: only a full +/-4 counts.
        if ((move == MOVE_CW || move == MOVE_CCW) && cur_ab == GRAY_DETENT) begin
            step_cw    = (phase_next == PHASE_POS);
            step_ccw   = (phase_next == PHASE_NEG);
            phase_next = 4'sd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab <= 2'b00;
            primed  <= 1'b0;
            phase   <= 4'sd0;
        end else begin
            prev_ab <= cur_ab;
            primed  <= 1'b1;
            phase   <= phase_next;
        end
    end

endmodule

// File: rtl/quad_encoder.sv
// Rotary-encoder setpoint counter with wrap or saturate arithmetic.
// Optional acceleration of repeated same-direction detents when ENC_ACCEL_EN is defined.
module quad_encoder
    import enc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int INIT         = 0,
    parameter int WRAP         = 1,
    parameter int ACCEL_WINDOW = 1000,
    parameter int ACCEL_STEP   = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic             step_cw;
    logic             step_ccw;
    logic             illegal;
    logic             moved;
    logic [WIDTH:0]   step_mag;
    logic [WIDTH-1:0] value_next;

    quad_phase u_phase (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .step_cw  (step_cw),
        .step_ccw (step_ccw),
        .illegal  (illegal)
    );

    assign moved = step_cw | step_ccw;

    function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] v, input logic [WIDTH:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, v} + m;
        if (WRAP == 0 && s[WIDTH]) return '1;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] v, input logic [WIDTH:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, v} - m;
        if (WRAP == 0 && s[WIDTH]) return '0;
        return s[WIDTH-1:0];
    endfunction

`ifdef ENC_ACCEL_EN
    localparam int GAP_W = (ACCEL_WINDOW < 1) ? 1 : $clog2(ACCEL_WINDOW + 1);
    logic [GAP_W-1:0] gap;

    // Cycles since the last step, parked at the window so the first step is never fast.
    always_ff @(posedge clk) begin
        if (reset)
            gap <= GAP_W'(ACCEL_WINDOW);
        else if (moved)
            gap <= '0;
        else if (gap != GAP_W'(ACCEL_WINDOW))
            gap <= gap + 1'b1;
    end
`else
    logic accel_params_unused;
    assign accel_params_unused = ^{ACCEL_WINDOW, ACCEL_STEP};
`endif

    always_comb begin
        step_mag = (WIDTH+1)'(1);
`ifdef ENC_ACCEL_EN
        if (gap < GAP_W'(ACCEL_WINDOW) && step_cw == dir)
            step_mag = (WIDTH+1)'(ACCEL_STEP);
`endif
        value_next = step_cw ? add_step(value, step_mag) : sub_step(value, step_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= WIDTH'(INIT);
            step  <= 1'b0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= moved;
            err  <= illegal;
            if (moved) begin
                value <= value_next;
                dir   <= step_cw;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder.sv
// Directed table-driven bench for quad_encoder: wrapping, saturating-low and
// saturating-high instances share one stimulus stream.
module tb_quad_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;

    logic [7:0] value_w, value_s, value_h;
    logic       step_w, step_s, step_h;
    logic       dir_w, dir_s, dir_h;
    logic       err_w, err_s, err_h;

    int checks = 0;
    int failures = 0;
    int sw, ss, sh, ew, es, eh, viol;

    always #5 clk = ~clk;

    quad_encoder #(.WIDTH(8), .INIT(0), .WRAP(1), .ACCEL_WINDOW(1), .ACCEL_STEP(4)) u_w (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .value(value_w), .step(step_w), .dir(dir_w), .err(err_w));

    quad_encoder #(.WIDTH(8), .INIT(0), .WRAP(0), .ACCEL_WINDOW(1), .ACCEL_STEP(4)) u_s (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .value(value_s), .step(step_s), .dir(dir_s), .err(err_s));

    quad_encoder #(.WIDTH(8), .INIT(255), .WRAP(0), .ACCEL_WINDOW(1), .ACCEL_STEP(4)) u_h (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .value(value_h), .step(step_h), .dir(dir_h), .err(err_h));

`ifdef ENC_ACCEL_EN
    logic [7:0] value_a;
    logic       step_a, dir_a, err_a;
    quad_encoder #(.WIDTH(8), .INIT(10), .WRAP(1), .ACCEL_WINDOW(1000), .ACCEL_STEP(4)) u_a (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .value(value_a), .step(step_a), .dir(dir_a), .err(err_a));
`endif

    typedef struct {
        logic [1:0] ab;
        int         vw;
        int         vs;
        int         vh;
        int         dir;
        int         steps;
        int         errs;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        sw = 0; ss = 0; sh = 0; ew = 0; es = 0; eh = 0;
    endtask

    // Advance n cycles, sampling outputs on the falling edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            sw += int'(step_w); ss += int'(step_s); sh += int'(step_h);
            ew += int'(err_w);  es += int'(err_s);  eh += int'(err_h);
            if ((step_w && err_w) || (step_s && err_s) || (step_h && err_h)) viol++;
        end
    endtask

    task automatic drive(input logic [1:0] ab);
        {a, b} = ab;
    endtask

    task automatic detent_cw(input int h);
        drive(2'b10); run(h);
        drive(2'b11); run(h);
        drive(2'b01); run(h);
        drive(2'b00); run(h);
    endtask

    task automatic add(input logic [1:0] ab, input int vw, input int vs, input int vh,
                       input int d, input int st, input int er);
        vec_t v;
        v.ab = ab; v.vw = vw; v.vs = vs; v.vh = vh; v.dir = d; v.steps = st; v.errs = er;
        tbl.push_back(v);
    endtask

    initial begin
        viol = 0;
        // Full CW detent from 0
        add(2'b00, 0, 0, 255, 0, 0, 0);
        add(2'b10, 0, 0, 255, 0, 0, 0);
        add(2'b11, 0, 0, 255, 0, 0, 0);
        add(2'b01, 0, 0, 255, 0, 0, 0);
        add(2'b00, 1, 1, 255, 1, 1, 0);
        // Two CCW detents: down to 0, then wrap to 255 / clamp at 0
        add(2'b01, 1, 1, 255, 1, 0, 0);
        add(2'b11, 1, 1, 255, 1, 0, 0);
        add(2'b10, 1, 1, 255, 1, 0, 0);
        add(2'b00, 0, 0, 254, 0, 1, 0);
        add(2'b01, 0, 0, 254, 0, 0, 0);
        add(2'b11, 0, 0, 254, 0, 0, 0);
        add(2'b10, 0, 0, 254, 0, 0, 0);
        add(2'b00, 255, 0, 253, 0, 1, 0);
        // CW from 255 wraps to 0
        add(2'b10, 255, 0, 253, 0, 0, 0);
        add(2'b11, 255, 0, 253, 0, 0, 0);
        add(2'b01, 255, 0, 253, 0, 0, 0);
        add(2'b00, 0, 1, 254, 1, 1, 0);
        // Partial rotation reversed back to the detent
        add(2'b10, 0, 1, 254, 1, 0, 0);
        add(2'b11, 0, 1, 254, 1, 0, 0);
        add(2'b10, 0, 1, 254, 1, 0, 0);
        add(2'b00, 0, 1, 254, 1, 0, 0);
        add(2'b10, 0, 1, 254, 1, 0, 0);
        add(2'b11, 0, 1, 254, 1, 0, 0);
        add(2'b01, 0, 1, 254, 1, 0, 0);
        add(2'b00, 1, 2, 255, 1, 1, 0);
        // Illegal jump, recovery, then a normal CW detent (high instance clamps)
        add(2'b11, 1, 2, 255, 1, 0, 1);
        add(2'b01, 1, 2, 255, 1, 0, 0);
        add(2'b00, 1, 2, 255, 1, 0, 0);
        add(2'b10, 1, 2, 255, 1, 0, 0);
        add(2'b11, 1, 2, 255, 1, 0, 0);
        add(2'b01, 1, 2, 255, 1, 0, 0);
        add(2'b00, 2, 3, 255, 1, 1, 0);

        // Reset state
        reset = 1'b1;
        drive(2'b00);
        clear_counts();
        run(3);
        check("rst_value_w", int'(value_w), 0);
        check("rst_value_h", int'(value_h), 255);
        check("rst_step", int'(step_w | step_s | step_h), 0);
        check("rst_dir", int'(dir_w | dir_h), 0);
        check("rst_err", int'(err_w | err_h), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            clear_counts();
            drive(tbl[i].ab);
            run(20);
            check($sformatf("v%0d_value_w", i), int'(value_w), tbl[i].vw);
            check($sformatf("v%0d_value_s", i), int'(value_s), tbl[i].vs);
            check($sformatf("v%0d_value_h", i), int'(value_h), tbl[i].vh);
            check($sformatf("v%0d_dir", i), int'(dir_w), tbl[i].dir);
            check($sformatf("v%0d_steps_w", i), sw, tbl[i].steps);
            check($sformatf("v%0d_steps_s", i), ss, tbl[i].steps);
            check($sformatf("v%0d_steps_h", i), sh, tbl[i].steps);
            check($sformatf("v%0d_errs_w", i), ew, tbl[i].errs);
            check($sformatf("v%0d_errs_s", i), es, tbl[i].errs);
        end

        // Reset while mid-rotation at 11, then return to the detent
        clear_counts();
        drive(2'b10); run(5);
        drive(2'b11); run(5);
        reset = 1'b1;
        run(3);
        check("midrst_value_w", int'(value_w), 0);
        check("midrst_value_h", int'(value_h), 255);
        check("midrst_dir", int'(dir_w), 0);
        reset = 1'b0;
        clear_counts();
        run(5);
        drive(2'b01); run(5);
        drive(2'b00); run(10);
        check("midrst_steps", sw + ss + sh, 0);
        check("midrst_errs", ew + es + eh, 0);
        check("midrst_final_w", int'(value_w), 0);
        check("midrst_final_h", int'(value_h), 255);

        // One-cycle latency from the completing 00 to step/value
        drive(2'b10); run(5);
        drive(2'b11); run(5);
        drive(2'b01); run(5);
        check("lat_pre_value", int'(value_w), 0);
        drive(2'b00);
        run(1);
        check("lat_step", int'(step_w), 1);
        check("lat_value", int'(value_w), 1);
        check("lat_dir", int'(dir_w), 1);
        run(1);
        check("lat_step_clear", int'(step_w), 0);
        check("lat_value_hold", int'(value_w), 1);

`ifdef ENC_ACCEL_EN
        reset = 1'b1;
        drive(2'b00);
        run(3);
        reset = 1'b0;
        run(5);
        check("acc_init", int'(value_a), 10);
        detent_cw(10);
        check("acc_first", int'(value_a), 11);
        run(160);
        detent_cw(10);
        check("acc_second", int'(value_a), 15);
        run(2000);
        detent_cw(10);
        check("acc_third", int'(value_a), 16);
`endif

        check("step_err_exclusive", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
